// File: rtl/alu_operand_mux_if.sv
// alu_operand_mux_if: operand-B select bus between decoder/register file and the ALU; imm_count only with MUX_IMM_COUNT_EN
interface alu_operand_mux_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  logic [DATA_W-1:0] rdata2;
  logic [IMM_W-1:0]  imm;
  logic              datasrc;
  logic [1:0]        ext_sel;
  logic              in_valid;
  logic [DATA_W-1:0] r3;
  logic              out_valid;
`ifdef MUX_IMM_COUNT_EN
  logic [15:0]       imm_count;
`endif
  modport master (
    output rdata2, imm, datasrc, ext_sel, in_valid,
    input  r3, out_valid
`ifdef MUX_IMM_COUNT_EN
    , input imm_count
`endif
  );
  modport slave (
    input  rdata2, imm, datasrc, ext_sel, in_valid,
    output r3, out_valid
`ifdef MUX_IMM_COUNT_EN
    , output imm_count
`endif
  );
endinterface

// File: rtl/alu_operand_mux.sv
// alu_operand_mux: registered ALU operand-B select (rdata2 or extended imm); MUX_IMM_COUNT_EN adds a saturating imm-use counter
module alu_operand_mux #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_operand_mux_if.slave  bus
);
  logic [DATA_W-1:0] ext_imm, sel, r3_d, r3_q;
  logic              out_valid_d, out_valid_q;
  // extend the immediate; reserved mode 11 falls back to sign extension
  always_comb begin
    ext_imm = DATA_W'($signed(bus.imm));
    ext_imm = bus.ext_sel == 2'b01 ? DATA_W'(bus.imm)
            : bus.ext_sel == 2'b10 ? DATA_W'(bus.imm) << (DATA_W - IMM_W)
            : ext_imm;
  end
  // pick the operand and hold r3 when no new input arrives
  always_comb begin
    sel         = bus.datasrc ? ext_imm : bus.rdata2;
    r3_d        = bus.in_valid ? sel : r3_q;
    out_valid_d = bus.in_valid;
  end
  // output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      r3_q        <= r3_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.r3        = r3_q;
  assign bus.out_valid = out_valid_q;
`ifdef MUX_IMM_COUNT_EN
  logic [15:0] imm_count_d, imm_count_q;
  // count accepted immediate selections, sticking at all-ones
  always_comb begin
    imm_count_d = (bus.in_valid && bus.datasrc && imm_count_q != 16'hFFFF) ? imm_count_q + 16'd1 : imm_count_q;
  end
  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) imm_count_q <= '0;
    else imm_count_q <= imm_count_d;
  end
  assign bus.imm_count = imm_count_q;
`endif
endmodule

// File: tb/tb_alu_operand_mux.sv
// tb_alu_operand_mux: randomized and directed checks of alu_operand_mux against an arithmetic reference model
module tb_alu_operand_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  alu_operand_mux_if #(.DATA_W(32), .IMM_W(16)) bus();
  alu_operand_mux #(.DATA_W(32), .IMM_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] ext(logic [15:0] im, logic [1:0] es);
    int v;
    v = int'(im);
    if (es == 2'b01) return v;
    if (es == 2'b10) return v * 65536;
    return im >= 16'd32768 ? v - 65536 : v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  logic [31:0] m_r3;
  logic        m_v;
  int          m_cnt;
  // reference model: what r3/out_valid/imm_count must be after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r3 <= 0; m_v <= 0; m_cnt <= 0;
    end else begin
      if (bus.in_valid) m_r3 <= bus.datasrc ? ext(bus.imm, bus.ext_sel) : bus.rdata2;
      m_v <= bus.in_valid;
      if (bus.in_valid && bus.datasrc && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  end
  // compare DUT against the model on every falling edge outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("r3", bus.r3, m_r3);
      chk("out_valid", 32'(bus.out_valid), 32'(m_v));
`ifdef MUX_IMM_COUNT_EN
      chk("imm_count", 32'(bus.imm_count), 32'(m_cnt));
`endif
    end
  end
  task automatic drive(logic v, logic ds, logic [1:0] es, logic [15:0] im, logic [31:0] rd);
    bus.in_valid = v; bus.datasrc = ds; bus.ext_sel = es; bus.imm = im; bus.rdata2 = rd;
    @(posedge clk); #1;
  endtask
  initial begin
    bus.in_valid = 0; bus.datasrc = 0; bus.ext_sel = 0; bus.imm = 0; bus.rdata2 = 0;
    chk("model_ext00", ext(16'h8001, 2'b00), 32'hFFFF8001);
    chk("model_ext01", ext(16'h8001, 2'b01), 32'h00008001);
    chk("model_ext10", ext(16'h8001, 2'b10), 32'h80010000);
    chk("model_ext11", ext(16'h8001, 2'b11), 32'hFFFF8001);
    #1;
    chk("rst_r3", bus.r3, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    repeat (2) drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 2'b00, 16'd1, 32'h0);
    chk("regpath_r3", bus.r3, 32'h0);
    chk("regpath_valid", 32'(bus.out_valid), 32'h1);
    drive(1, 1, 2'b00, 16'd1, 32'h0);
    chk("immpath_r3", bus.r3, 32'h00000001);
    drive(1, 1, 2'b00, 16'h8001, 32'h0); chk("ext00_r3", bus.r3, 32'hFFFF8001);
    drive(1, 1, 2'b01, 16'h8001, 32'h0); chk("ext01_r3", bus.r3, 32'h00008001);
    drive(1, 1, 2'b10, 16'h8001, 32'h0); chk("ext10_r3", bus.r3, 32'h80010000);
    drive(1, 1, 2'b11, 16'h8001, 32'h0); chk("ext11_r3", bus.r3, 32'hFFFF8001);
    drive(1, 0, 2'b10, 16'hFFFF, 32'hDEADBEEF);
    chk("load_r3", bus.r3, 32'hDEADBEEF);
    drive(0, 0, 2'b00, 16'h0, 32'h12345678);
    chk("hold_r3", bus.r3, 32'hDEADBEEF);
    chk("hold_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1, i[0], 2'($urandom), 16'($urandom), $urandom);
      chk("thru_valid", 32'(bus.out_valid), 32'h1);
    end
    for (int i = 0; i < 300; i++)
      drive(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), $urandom);
    drive(1, 0, 2'b00, 16'h0, 32'hCAFEF00D);
    bus.in_valid = 1; bus.rdata2 = 32'h11111111;
    rst_n = 1'b0;
    #1;
    chk("midrst_r3", bus.r3, 32'h0);
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("postrst_r3", bus.r3, 32'h0);
`ifdef MUX_IMM_COUNT_EN
    chk("cnt_reset", 32'(bus.imm_count), 32'h0);
    repeat (5) drive(1, 1, 2'($urandom), 16'($urandom), $urandom);
    repeat (3) drive(1, 0, 2'($urandom), 16'($urandom), $urandom);
    chk("cnt_five", 32'(bus.imm_count), 32'd5);
    repeat (65535) drive(1, 1, 2'b01, 16'($urandom), 32'h0);
    chk("cnt_sat", 32'(bus.imm_count), 32'h0000FFFF);
    drive(1, 1, 2'b00, 16'h1, 32'h0);
    chk("cnt_sat_hold", 32'(bus.imm_count), 32'h0000FFFF);
`endif
    drive(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
